// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite channel widths and skid buffer state encoding.
// Channel payload widths are derived from one configuration struct.
package axi4_lite_pkg;

  typedef struct packed {
    int unsigned addr_w;
    int unsigned data_bytes;
    bit          use_strb;
  } axi4_lite_cfg_t;

  localparam int unsigned RespW = 2;

  typedef enum logic [1:0] {
    SkidEmpty,
    SkidBusy,
    SkidFull
  } skid_state_e;

  function automatic int unsigned ar_w(axi4_lite_cfg_t cfg);
    return cfg.addr_w;
  endfunction

  function automatic int unsigned aw_w(axi4_lite_cfg_t cfg);
    return cfg.addr_w;
  endfunction

  // {data, strb}
  function automatic int unsigned w_w(axi4_lite_cfg_t cfg);
    return 8 * cfg.data_bytes + (cfg.use_strb ? cfg.data_bytes : 0);
  endfunction

  function automatic int unsigned b_w();
    return RespW;
  endfunction

  // {data, resp}
  function automatic int unsigned r_w(axi4_lite_cfg_t cfg);
    return 8 * cfg.data_bytes + RespW;
  endfunction

endpackage

// File: rtl/axi4_lite_skid_buffer.sv
// Two-entry skid buffer for one valid/ready channel; every output comes
// straight from a flop so no timing path crosses the slice.
module axi4_lite_skid_buffer
  import axi4_lite_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  skid_state_e  r_state;
  skid_state_e  w_state_d;
  logic [W-1:0] r_out_data;
  logic [W-1:0] w_out_data_d;
  logic [W-1:0] r_skid_data;
  logic [W-1:0] w_skid_data_d;
  logic         r_out_valid;
  logic         r_in_ready;
  logic         w_accept;

  assign w_accept = i_in_valid & r_in_ready;

  // Data regs load only on an accepted beat, so idle input bits never leak out.
  always_comb begin
    w_state_d     = r_state;
    w_out_data_d  = r_out_data;
    w_skid_data_d = r_skid_data;
    unique case (r_state)
      SkidEmpty: begin
        if (w_accept) begin
          w_out_data_d = i_in_data;
          w_state_d    = SkidBusy;
        end
      end
      SkidBusy: begin
        if (w_accept && i_out_ready) begin
          w_out_data_d = i_in_data;
        end else if (w_accept) begin
          w_skid_data_d = i_in_data;
          w_state_d     = SkidFull;
        end else if (i_out_ready) begin
          w_state_d = SkidEmpty;
        end
      end
      SkidFull: begin
        if (i_out_ready) begin
          w_out_data_d = r_skid_data;
          w_state_d    = SkidBusy;
        end
      end
      default: w_state_d = SkidEmpty;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SkidEmpty;
      r_out_data  <= '0;
      r_skid_data <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_out_data  <= w_out_data_d;
      r_skid_data <= w_skid_data_d;
      r_out_valid <= (w_state_d != SkidEmpty);
      r_in_ready  <= (w_state_d != SkidFull);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

endmodule

// File: rtl/axi4_lite_reg_slice.sv
// AXI4-Lite register slice: one independent skid buffer per channel.
// AR/AW/W flow master side (s_*) to slave side (m_*); B/R flow back.
module axi4_lite_reg_slice
  import axi4_lite_pkg::*;
#(
  parameter int unsigned     A        = 32,
  parameter int unsigned     N        = 4,
  parameter bit              USE_STRB = 1'b1,
  localparam axi4_lite_cfg_t Cfg      = '{addr_w: A, data_bytes: N, use_strb: USE_STRB},
  localparam int unsigned    ArW      = ar_w(Cfg),
  localparam int unsigned    AwW      = aw_w(Cfg),
  localparam int unsigned    WW       = w_w(Cfg),
  localparam int unsigned    BW       = b_w(),
  localparam int unsigned    RW       = r_w(Cfg)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [ArW-1:0] s_ar_flat,
  input  logic           s_ar_valid,
  output logic           s_ar_ready,
  input  logic [AwW-1:0] s_aw_flat,
  input  logic           s_aw_valid,
  output logic           s_aw_ready,
  input  logic [WW-1:0]  s_w_flat,
  input  logic           s_w_valid,
  output logic           s_w_ready,
  output logic [BW-1:0]  s_b_flat,
  output logic           s_b_valid,
  input  logic           s_b_ready,
  output logic [RW-1:0]  s_r_flat,
  output logic           s_r_valid,
  input  logic           s_r_ready,
  output logic [ArW-1:0] m_ar_flat,
  output logic           m_ar_valid,
  input  logic           m_ar_ready,
  output logic [AwW-1:0] m_aw_flat,
  output logic           m_aw_valid,
  input  logic           m_aw_ready,
  output logic [WW-1:0]  m_w_flat,
  output logic           m_w_valid,
  input  logic           m_w_ready,
  input  logic [BW-1:0]  m_b_flat,
  input  logic           m_b_valid,
  output logic           m_b_ready,
  input  logic [RW-1:0]  m_r_flat,
  input  logic           m_r_valid,
  output logic           m_r_ready
);

  axi4_lite_skid_buffer #(.W(ArW)) u_ar (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_in_valid  (s_ar_valid),
    .o_in_ready  (s_ar_ready),
    .i_in_data   (s_ar_flat),
    .o_out_valid (m_ar_valid),
    .i_out_ready (m_ar_ready),
    .o_out_data  (m_ar_flat)
  );

  axi4_lite_skid_buffer #(.W(AwW)) u_aw (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_in_valid  (s_aw_valid),
    .o_in_ready  (s_aw_ready),
    .i_in_data   (s_aw_flat),
    .o_out_valid (m_aw_valid),
    .i_out_ready (m_aw_ready),
    .o_out_data  (m_aw_flat)
  );

  axi4_lite_skid_buffer #(.W(WW)) u_w (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_in_valid  (s_w_valid),
    .o_in_ready  (s_w_ready),
    .i_in_data   (s_w_flat),
    .o_out_valid (m_w_valid),
    .i_out_ready (m_w_ready),
    .o_out_data  (m_w_flat)
  );

  axi4_lite_skid_buffer #(.W(BW)) u_b (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_in_valid  (m_b_valid),
    .o_in_ready  (m_b_ready),
    .i_in_data   (m_b_flat),
    .o_out_valid (s_b_valid),
    .i_out_ready (s_b_ready),
    .o_out_data  (s_b_flat)
  );

  axi4_lite_skid_buffer #(.W(RW)) u_r (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_in_valid  (m_r_valid),
    .o_in_ready  (m_r_ready),
    .i_in_data   (m_r_flat),
    .o_out_valid (s_r_valid),
    .i_out_ready (s_r_ready),
    .o_out_data  (s_r_flat)
  );

endmodule

// File: tb/tb_axi4_lite_reg_slice.sv
// Self-checking bench for axi4_lite_reg_slice: each channel is modelled as
// a two-deep FIFO whose occupancy sets the expected valid, ready and head.
module tb_axi4_lite_reg_slice;

  localparam int unsigned A   = 32;
  localparam int unsigned N   = 4;
  localparam int unsigned WW  = 8 * N + N;
  localparam int unsigned RW  = 8 * N + 2;
  localparam int          NCH = 5;
  localparam int          CH_AR = 0, CH_AW = 1, CH_W = 2, CH_B = 3, CH_R = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // Source-side drive and sink-side ready, per channel
  logic        tb_vld [NCH];
  logic [63:0] tb_dat [NCH];
  logic        tb_rdy [NCH];

  logic          s_ar_ready, s_aw_ready, s_w_ready, m_b_ready, m_r_ready;
  logic          m_ar_valid, m_aw_valid, m_w_valid, s_b_valid, s_r_valid;
  logic [A-1:0]  m_ar_flat, m_aw_flat;
  logic [WW-1:0] m_w_flat;
  logic [1:0]    s_b_flat;
  logic [RW-1:0] s_r_flat;

  axi4_lite_reg_slice #(.A(A), .N(N), .USE_STRB(1'b1)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_ar_flat  (tb_dat[CH_AR][A-1:0]),
    .s_ar_valid (tb_vld[CH_AR]),
    .s_ar_ready (s_ar_ready),
    .s_aw_flat  (tb_dat[CH_AW][A-1:0]),
    .s_aw_valid (tb_vld[CH_AW]),
    .s_aw_ready (s_aw_ready),
    .s_w_flat   (tb_dat[CH_W][WW-1:0]),
    .s_w_valid  (tb_vld[CH_W]),
    .s_w_ready  (s_w_ready),
    .s_b_flat   (s_b_flat),
    .s_b_valid  (s_b_valid),
    .s_b_ready  (tb_rdy[CH_B]),
    .s_r_flat   (s_r_flat),
    .s_r_valid  (s_r_valid),
    .s_r_ready  (tb_rdy[CH_R]),
    .m_ar_flat  (m_ar_flat),
    .m_ar_valid (m_ar_valid),
    .m_ar_ready (tb_rdy[CH_AR]),
    .m_aw_flat  (m_aw_flat),
    .m_aw_valid (m_aw_valid),
    .m_aw_ready (tb_rdy[CH_AW]),
    .m_w_flat   (m_w_flat),
    .m_w_valid  (m_w_valid),
    .m_w_ready  (tb_rdy[CH_W]),
    .m_b_flat   (tb_dat[CH_B][1:0]),
    .m_b_valid  (tb_vld[CH_B]),
    .m_b_ready  (m_b_ready),
    .m_r_flat   (tb_dat[CH_R][RW-1:0]),
    .m_r_valid  (tb_vld[CH_R]),
    .m_r_ready  (m_r_ready)
  );

  int unsigned cw [NCH] = '{A, A, WW, 2, RW};
  string       cname [NCH] = '{"ar", "aw", "w", "b", "r"};

  // Reference model: FIFO contents and occupancy per channel
  logic [63:0] mq [NCH][2];
  int          mcnt [NCH];
  bit          rdy_en;
  bit          acc [NCH];
  int          popped [NCH];
  int          dut_hs [NCH];
  int          seq [NCH];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] cmask(input int ch);
    return (64'd1 << cw[ch]) - 64'd1;
  endfunction

  function automatic logic dut_ov(input int ch);
    case (ch)
      CH_AR:   return m_ar_valid;
      CH_AW:   return m_aw_valid;
      CH_W:    return m_w_valid;
      CH_B:    return s_b_valid;
      default: return s_r_valid;
    endcase
  endfunction

  function automatic logic dut_ir(input int ch);
    case (ch)
      CH_AR:   return s_ar_ready;
      CH_AW:   return s_aw_ready;
      CH_W:    return s_w_ready;
      CH_B:    return m_b_ready;
      default: return m_r_ready;
    endcase
  endfunction

  function automatic logic [63:0] dut_od(input int ch);
    case (ch)
      CH_AR:   return 64'(m_ar_flat);
      CH_AW:   return 64'(m_aw_flat);
      CH_W:    return 64'(m_w_flat);
      CH_B:    return 64'(s_b_flat);
      default: return 64'(s_r_flat);
    endcase
  endfunction

  task automatic check_all();
    for (int ch = 0; ch < NCH; ch++) begin
      logic eov, eir;
      eov = (mcnt[ch] > 0);
      eir = rdy_en && (mcnt[ch] < 2);
      chk_eq({cname[ch], "_out_valid"}, 64'(dut_ov(ch)), 64'(eov));
      chk_eq({cname[ch], "_in_ready"}, 64'(dut_ir(ch)), 64'(eir));
      if (eov) chk_eq({cname[ch], "_out_data"}, dut_od(ch) & cmask(ch), mq[ch][0]);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < NCH; ch++) begin
      mcnt[ch] = 0;
      acc[ch]  = 1'b0;
    end
    rdy_en = 1'b0;
  endtask

  // Predict the state after the coming rising edge from the applied inputs
  task automatic update_model();
    for (int ch = 0; ch < NCH; ch++) begin
      logic eov, eir;
      eov = (mcnt[ch] > 0);
      eir = rdy_en && (mcnt[ch] < 2);
      if (eov && tb_rdy[ch]) begin
        mq[ch][0] = mq[ch][1];
        mcnt[ch]--;
        popped[ch]++;
      end
      acc[ch] = tb_vld[ch] && eir;
      if (acc[ch]) begin
        mq[ch][mcnt[ch]] = tb_dat[ch] & cmask(ch);
        mcnt[ch]++;
      end
    end
    if (!aresetn) model_clear();
    else rdy_en = 1'b1;
  endtask

  task automatic cycle();
    @(negedge aclk);
    check_all();
    for (int ch = 0; ch < NCH; ch++) dut_hs[ch] += int'(dut_ov(ch) && tb_rdy[ch]);
    update_model();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [63:0] next_beat(input int ch);
    logic [1:0] resp;
    seq[ch]++;
    if (ch == CH_R) begin
      resp = (seq[ch] % 7 == 0) ? 2'b10 : 2'b00;
      return 64'({32'(seq[ch]), resp});
    end
    return {$urandom(), $urandom()} & cmask(ch);
  endfunction

  // Random source that holds an unaccepted beat, plus random sink ready
  task automatic rand_drive(input int ch, input int pv, input int pr);
    if (!(tb_vld[ch] && !acc[ch])) begin
      if ($urandom_range(99) < pv) begin
        tb_vld[ch] = 1'b1;
        tb_dat[ch] = next_beat(ch);
      end else begin
        tb_vld[ch] = 1'b0;
        tb_dat[ch] = 'x;
      end
    end
    tb_rdy[ch] = ($urandom_range(99) < pr);
  endtask

  task automatic idle_drain(input int cycles);
    for (int ch = 0; ch < NCH; ch++) begin
      tb_vld[ch] = 1'b0;
      tb_dat[ch] = 'x;
      tb_rdy[ch] = 1'b1;
    end
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      tb_vld[ch] = 1'b0;
      tb_dat[ch] = '0;
      tb_rdy[ch] = 1'b0;
      popped[ch] = 0;
      dut_hs[ch] = 0;
      seq[ch]    = 0;
    end
    model_clear();

    // Reset held 3 cycles, then readies come up on the first edge after release
    for (int i = 0; i < 3; i++) cycle();
    aresetn = 1'b1;
    for (int i = 0; i < 2; i++) cycle();

    // AR streaming, sink always ready: 16 beats, no bubbles
    tb_rdy[CH_AR] = 1'b1;
    dut_hs[CH_AR] = 0;
    for (int i = 0; i < 16; i++) begin
      tb_vld[CH_AR] = 1'b1;
      tb_dat[CH_AR] = 64'(i * 4);
      cycle();
    end
    tb_vld[CH_AR] = 1'b0;
    cycle();
    chk_eq("ar_stream_beats", 64'(dut_hs[CH_AR]), 64'd16);
    idle_drain(2);

    // W backpressure: two beats stored, third held off until release
    tb_rdy[CH_W] = 1'b0;
    tb_vld[CH_W] = 1'b1;
    tb_dat[CH_W] = 64'({32'hAAAA0001, 4'hF});
    cycle();
    tb_dat[CH_W] = 64'({32'hAAAA0002, 4'h3});
    cycle();
    tb_dat[CH_W] = 64'({32'hAAAA0003, 4'hF});
    for (int i = 0; i < 3; i++) cycle();
    chk_eq("w_ready_low_when_full", 64'(s_w_ready), 64'd0);
    tb_rdy[CH_W] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (acc[CH_W]) tb_vld[CH_W] = 1'b0;
      cycle();
    end
    chk_eq("w_all_beats_out", 64'(popped[CH_W]), 64'd3);
    idle_drain(2);

    // R random valid/ready, 10k beats against the model FIFO
    begin
      int budget;
      budget = 0;
      while (popped[CH_R] < 10000 && budget < 50000) begin
        rand_drive(CH_R, 70, 70);
        cycle();
        budget++;
      end
      chk_eq("r_10k_beats_within_budget", 64'(popped[CH_R] >= 10000), 64'd1);
    end
    idle_drain(3);

    // AW reset while FULL: stored beats vanish, 0x100 is the first output
    tb_rdy[CH_AW] = 1'b0;
    tb_vld[CH_AW] = 1'b1;
    tb_dat[CH_AW] = 64'h10;
    cycle();
    tb_dat[CH_AW] = 64'h20;
    cycle();
    tb_dat[CH_AW] = 64'h30;
    chk_eq("aw_valid_before_reset", 64'(m_aw_valid), 64'd1);
    aresetn = 1'b0;
    model_clear();
    #1;
    chk_eq("aw_valid_drops_async", 64'(m_aw_valid), 64'd0);
    check_all();
    tb_vld[CH_AW] = 1'b0;
    tb_dat[CH_AW] = 'x;
    cycle();
    cycle();
    aresetn = 1'b1;
    tb_vld[CH_AW] = 1'b1;
    tb_dat[CH_AW] = 64'h100;
    tb_rdy[CH_AW] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (acc[CH_AW]) begin
        tb_vld[CH_AW] = 1'b0;
        tb_dat[CH_AW] = 'x;
      end
      cycle();
    end
    chk_eq("aw_first_after_reset", 64'(m_aw_flat), 64'h100);
    idle_drain(2);

    // Independence: B stalled while AR and R run at full rate
    tb_vld[CH_B] = 1'b1;
    tb_dat[CH_B] = 64'h1;
    tb_rdy[CH_B] = 1'b0;
    tb_rdy[CH_AR] = 1'b1;
    tb_rdy[CH_R]  = 1'b1;
    dut_hs[CH_AR] = 0;
    dut_hs[CH_R]  = 0;
    for (int i = 0; i < 20; i++) begin
      tb_vld[CH_AR] = 1'b1;
      tb_dat[CH_AR] = 64'(32'h200 + i * 4);
      tb_vld[CH_R]  = 1'b1;
      tb_dat[CH_R]  = next_beat(CH_R);
      cycle();
    end
    chk_eq("ar_full_rate_b_stalled", 64'(dut_hs[CH_AR]), 64'd19);
    chk_eq("r_full_rate_b_stalled", 64'(dut_hs[CH_R]), 64'd19);
    chk_eq("b_still_stalled", 64'(s_b_valid), 64'd1);
    idle_drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slice.md
Name: axi4_lite_reg_slice

Overview:
- Full register slice for one AXI4-Lite link, carried on flattened channel vectors (ar/aw/w/b/r packed payloads).
- Sits between a master-side and a slave-side AXI4-Lite interface instance.
  - Consumes the master side's *_flat_in vectors and drives the slave side's *_flat_out vectors for AR/AW/W.
  - Does the reverse for B/R.
- Breaks every valid, ready and payload timing path with a 2-entry skid buffer per channel, at full throughput.

Parameters:
- A, 32, address width in bits.
- N, 4, data width in bytes (data = 8*N bits).
- USE_STRB, 1, W payload carries strobe when 1; widths follow the shared package functions.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_ar_flat / s_aw_flat  in  A  address payload from master side.
- s_w_flat  in  W_W  write payload {data,strb} from master side; W_W = 8N+(USE_STRB?N:0).
- s_ar_valid / s_aw_valid / s_w_valid  in  1  request valids from master side.
- s_ar_ready / s_aw_ready / s_w_ready  out  1  request readies to master side.
- s_b_flat  out  2  write response to master side.
- s_r_flat  out  8N+2  read response {data,resp} to master side.
- s_b_valid / s_r_valid  out  1; s_b_ready / s_r_ready  in  1.
- m_ar_flat / m_aw_flat  out  A; m_w_flat  out  W_W; m_ar_valid / m_aw_valid / m_w_valid  out  1; m_ar_ready / m_aw_ready / m_w_ready  in  1.
- m_b_flat  in  2; m_r_flat  in  8N+2; m_b_valid / m_r_valid  in  1; m_b_ready / m_r_ready  out  1.

Behaviour:
- Five independent channel instances:
  - AR, AW, W: s->m.
  - B, R: m->s.
- No inter-channel ordering or coupling; payload bits pass unmodified.
- Per channel, terms: in_valid/in_ready/in_data on the source side, out_valid/out_ready/out_data on the sink side.
- State machine per channel:
  - EMPTY: out_valid=0, in_ready=1.
    - in_valid -> capture into output reg, go BUSY.
  - BUSY: out_valid=1, in_ready=1.
    - in_valid & out_ready: output reg reloads, stay BUSY.
    - in_valid & !out_ready: capture into skid reg, go FULL.
    - !in_valid & out_ready: go EMPTY.
  - FULL: out_valid=1, in_ready=0.
    - out_ready: skid reg -> output reg, go BUSY.
- Outputs are all driven from flops; no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Latency: 1 cycle from an accepted in_valid to out_valid.
- Throughput: 1 beat/cycle sustained when out_ready is held high.
- Ordering: strict FIFO; the skid entry always leaves before any newer beat.
- Payload held stable while out_valid & !out_ready (AXI rule), including across the BUSY->FULL transition.
- in_ready only falls after 2 beats are stored; it rises the cycle after the skid entry drains.
- Reset (aresetn low, asynchronous):
  - All channels EMPTY.
  - out_valid=0, data regs=0.
  - in_ready held 0 while aresetn is low; in_ready=1 on the first clock edge after deassertion.
- Reset mid-transfer: stored beats are discarded with no partial-output glitch; out_valid drops immediately (asynchronously).
- in_valid while in_ready=0: ignored, not captured.
- X on in_data while !in_valid: must not propagate to out_data.

Decomposition:
- axi4_lite_pkg:
  - Width functions ar_w(cfg), aw_w(cfg), w_w(cfg), b_w(), r_w(cfg), consistent with the interface struct packing.
  - Skid state enum {EMPTY, BUSY, FULL}.
- Sub-module axi4_lite_skid_buffer #(W): one channel's state machine and the output/skid regs.
  - Instantiated 5 times with the channel widths.
- Top is wiring only.

Test Plan:
- Reset then idle:
  - aresetn low 3 cycles -> all valids 0, all readies 0.
  - First edge after release -> all s_*_ready and m_b_ready/m_r_ready = 1.
- Streaming AR, m_ar_ready held 1: addresses 0x0,0x4,...,0x3C on 16 consecutive cycles -> same 16 addresses on m_ar_flat, each 1 cycle later, no bubbles.
- Backpressure on W, USE_STRB=1: wdata 0xAAAA0001/strb 0xF, then 0xAAAA0002/strb 0x3 with m_w_ready=0 -> s_w_ready=0 after the 2nd beat and the 3rd beat is held off. Release m_w_ready -> beats emerge in order with strobes intact.
- R channel random valid/ready (10k beats, incrementing data, resp 2'b10 every 7th) -> scoreboard exact order and resp match; valid never drops without a handshake.
- Reset asserted while in FULL on AW -> m_aw_valid=0 immediately; after release, the next beat 0x100 is the first output and the old beats are never seen.
- Independence: B stalled with m_b_valid=1 and s_b_ready=0 for 20 cycles -> AR/R traffic continues at full rate.
